// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared PC width, reset vector and run-control state encoding
package cpu_pkg;

  localparam int          PC_W         = 16;
  localparam logic [15:0] RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - sequential, PC-relative branch and page-jump target arithmetic
module pc_target_calc #(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [7:0]      imm_i,
  output logic [PC_W-1:0] pc1_o,
  output logic [PC_W-1:0] btgt_o,
  output logic [PC_W-1:0] jtgt_o
);

  // Targets are relative to the instruction after the current one, so the
  // branch offset and the jump page both come from pc1, not pc_i.
  always_comb begin
    pc1_o  = pc_i + PC_W'(1);
    btgt_o = pc1_o + {{(PC_W-8){imm_i[7]}}, imm_i};
    jtgt_o = {pc1_o[PC_W-1:8], imm_i};
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC select, run-control FSM, PC mirror and retired-instruction counter
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W         = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(cpu_pkg::RESET_VECTOR),
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic             zero,
  input  logic [7:0]       imm,
  output logic [PC_W-1:0]  pcFill,
  output logic [PC_W-1:0]  pc_q,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_t            state_q, state_d;
  logic              retire;
  logic [PC_W-1:0]   pc1, btgt, jtgt;

  pc_target_calc #(.PC_W(PC_W)) u_target (
    .pc_i   (pc_q),
    .imm_i  (imm),
    .pc1_o  (pc1),
    .btgt_o (btgt),
    .jtgt_o (jtgt)
  );

  // Next-state and next-PC select; pcFill defaults to holding the current PC.
  always_comb begin
    state_d = state_q;
    pcFill  = pc_q;
    retire  = 1'b0;
    if (rst) begin
      state_d = IDLE;
      pcFill  = RESET_VECTOR;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            state_d = RUN;
            pcFill  = RESET_VECTOR;
          end
        end
        HALT: begin
          if (go) begin
            state_d = RUN;
            pcFill  = pc1;
          end
        end
        RUN: begin
          if (!stall) begin
            retire = 1'b1;
            if (halt_req) begin
              state_d = HALT;
            end else if (jump_en) begin
              pcFill = jtgt;
            end else if (branch_en && zero) begin
              pcFill = btgt;
            end else begin
              pcFill = pc1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          pcFill  = RESET_VECTOR;
        end
      endcase
    end
  end

  // State, PC mirror, registered status decodes and retired-instruction count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      running <= 1'b0;
      halted  <= 1'b0;
      instret <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pcFill;
      running <= (state_d == RUN);
      halted  <= (state_d == HALT);
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, go, stall, halt_req, jump_en, branch_en, zero;
  logic [7:0]  imm;
  logic [15:0] pcFill, pc_q, instret;
  logic        running, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .stall     (stall),
    .halt_req  (halt_req),
    .jump_en   (jump_en),
    .branch_en (branch_en),
    .zero      (zero),
    .imm       (imm),
    .pcFill    (pcFill),
    .pc_q      (pc_q),
    .running   (running),
    .halted    (halted),
    .instret   (instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_ctl();
    go = 0; stall = 0; halt_req = 0; jump_en = 0; branch_en = 0; zero = 0; imm = 8'h00;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] pc, input logic run,
                           input logic hlt, input logic [15:0] cnt);
    chk({tag, ".pc_q"},    32'(pc_q),    32'(pc));
    chk({tag, ".running"}, 32'(running), 32'(run));
    chk({tag, ".halted"},  32'(halted),  32'(hlt));
    chk({tag, ".instret"}, 32'(instret), 32'(cnt));
  endtask

  initial begin
    clear_ctl();
    rst = 1;
    #2;
    step();
    settle();
    chk("rst_pcfill", 32'(pcFill), 32'h0000);
    step();
    chk_state("reset", 16'h0000, 0, 0, 16'd0);

    rst = 0;
    settle();
    chk("idle_pcfill", 32'(pcFill), 32'h0000);
    step();
    chk_state("idle_hold", 16'h0000, 0, 0, 16'd0);

    go = 1;
    settle();
    chk("go_pcfill", 32'(pcFill), 32'h0000);
    step();
    go = 0;
    chk_state("start0", 16'h0000, 1, 0, 16'd0);
    step();
    chk_state("start1", 16'h0001, 1, 0, 16'd1);
    go = 1;
    step();
    go = 0;
    chk_state("start2_go_ignored", 16'h0002, 1, 0, 16'd2);

    jump_en = 1; imm = 8'h10;
    settle();
    chk("jump_0010_pcfill", 32'(pcFill), 32'h0010);
    step();
    chk_state("at_0010", 16'h0010, 1, 0, 16'd3);

    jump_en = 0; branch_en = 1; zero = 1; imm = 8'hFC;
    settle();
    chk("branch_taken_pcfill", 32'(pcFill), 32'h000D);
    zero = 0;
    settle();
    chk("branch_not_taken_pcfill", 32'(pcFill), 32'h0011);
    zero = 1;
    step();
    chk_state("at_000D", 16'h000D, 1, 0, 16'd4);

    imm = 8'hF7;
    step();
    chk_state("at_0005", 16'h0005, 1, 0, 16'd5);

    stall = 1;
    settle();
    chk("stall_pcfill", 32'(pcFill), 32'h0005);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("stall_hold", 16'h0005, 1, 0, 16'd5);
    end
    stall = 0; imm = 8'h80;
    settle();
    chk("branch_neg128_pcfill", 32'(pcFill), 32'hFF86);
    clear_ctl();
    step();
    chk_state("at_0006", 16'h0006, 1, 0, 16'd6);

    jump_en = 1; imm = 8'h20;
    step();
    chk_state("at_0020", 16'h0020, 1, 0, 16'd7);

    clear_ctl();
    halt_req = 1;
    settle();
    chk("halt_pcfill", 32'(pcFill), 32'h0020);
    step();
    chk_state("halted", 16'h0020, 0, 1, 16'd8);
    halt_req = 0; jump_en = 1; imm = 8'h55;
    settle();
    chk("halt_ignore_pcfill", 32'(pcFill), 32'h0020);
    step();
    chk_state("halt_hold", 16'h0020, 0, 1, 16'd8);
    clear_ctl();
    go = 1;
    settle();
    chk("resume_pcfill", 32'(pcFill), 32'h0021);
    step();
    go = 0;
    chk_state("resumed", 16'h0021, 1, 0, 16'd8);
    step();
    chk_state("after_resume", 16'h0022, 1, 0, 16'd9);

    jump_en = 1; imm = 8'hFF;
    for (int i = 0; i < 19; i++) step();
    chk_state("at_12FF", 16'h12FF, 1, 0, 16'd28);
    branch_en = 1; zero = 1; imm = 8'h40;
    settle();
    chk("jump_prio_page_pcfill", 32'(pcFill), 32'h1340);
    step();
    chk_state("at_1340", 16'h1340, 1, 0, 16'd29);

    clear_ctl();
    jump_en = 1; imm = 8'hFF;
    for (int i = 0; i < 237; i++) step();
    chk_state("at_FFFF", 16'hFFFF, 1, 0, 16'd266);
    clear_ctl();
    settle();
    chk("wrap_pcfill", 32'(pcFill), 32'h0000);
    step();
    chk_state("wrapped", 16'h0000, 1, 0, 16'd267);

    halt_req = 1;
    step();
    halt_req = 0;
    chk_state("halt2", 16'h0000, 0, 1, 16'd268);
    rst = 1; go = 1;
    settle();
    chk("rst_halt_pcfill", 32'(pcFill), 32'h0000);
    step();
    rst = 0; go = 0;
    chk_state("rst_mid_halt", 16'h0000, 0, 0, 16'd0);

    go = 1;
    step();
    go = 0;
    step();
    chk_state("restart", 16'h0001, 1, 0, 16'd1);
    stall = 1;
    step();
    chk_state("stall2", 16'h0001, 1, 0, 16'd1);
    rst = 1;
    settle();
    chk("rst_stall_pcfill", 32'(pcFill), 32'h0000);
    step();
    rst = 0; stall = 0;
    chk_state("rst_mid_stall", 16'h0000, 0, 0, 16'd0);
    step();
    chk_state("idle_after_rst", 16'h0000, 0, 0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
